dbus_bridge: RTL and testbench
==============================

// Module: dbus_bridge
// PURPOSE
//   Multi-cycle data-bus bridge between the core's load/store port and an external
//   valid/ready memory/peripheral bus with wait states.
//   - Converts each core load or store into one bus transaction: word-aligned address,
//     byte strobes, lane-shifted write data, and sign/zero-extended read data.
//   - Stalls the core (PC hold) until the transaction completes; flags misalignment,
//     bus error and timeout as a fault.
// PARAMETERS
//   TIMEOUT_CYCLES  255  max BUS-state cycles waiting for bus_ready before fault (>=1)
//   TO_W            8    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//   clk          in   1   clock, rising edge
//   rstn         in   1   asynchronous active-low reset
//   core_req     in   1   load/store instruction present this cycle
//   core_we      in   1   1=store, 0=load
//   core_func    in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   core_addr    in   32  byte address (ALU result)
//   core_wdata   in   32  store data (rs2), LSB-aligned
//   core_rdata   out  32  extended load data, valid in DONE
//   core_stall   out  1   hold PC / suppress regfile write
//   core_fault   out  1   one-cycle fault pulse, in DONE
//   bus_valid    out  1   request valid
//   bus_ready    in   1   target accepts/completes request this cycle
//   bus_we       out  1   write enable
//   bus_addr     out  32  {core_addr[31:2],2'b00}
//   bus_wstrb    out  4   byte strobes (0000 on reads)
//   bus_wdata    out  32  lane-shifted store data
//   bus_rdata    in   32  read data, sampled when bus_valid&&bus_ready
//   bus_err      in   1   error response, qualified by bus_ready
// BEHAVIOUR
//   Reset (async, rstn=0): state=IDLE, timeout counter=0, all registered outputs 0.
//     bus_valid drops immediately, including mid-transaction; no completion is reported.
//   FSM states: IDLE, BUS, DONE.
//   IDLE
//     - core_stall = core_req, combinational.
//     - core_req && aligned: latch addr/we/func/wstrb/wdata; -> BUS.
//     - core_req && misaligned: -> DONE with fault=1; no bus cycle.
//     - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
//     - Illegal funct3 (011,110,111) is treated as misaligned (fault).
//   BUS
//     - bus_valid=1; bus_addr/we/wstrb/wdata are registered and held stable until handshake.
//     - core_stall=1.
//     - bus_ready=1: capture formatted read data (0 on writes); fault=bus_err; -> DONE.
//     - Else counter++.
//     - Counter reaches TIMEOUT_CYCLES without bus_ready: drop bus_valid, fault=1,
//       rdata=0; -> DONE.
//     - A late bus_ready after timeout is ignored.
//   DONE (exactly 1 cycle)
//     - core_stall=0; core_rdata valid; core_fault=fault; -> IDLE; counter cleared.
//     - The next instruction is evaluated in IDLE on the following cycle.
//   Minimum load/store latency: 3 cycles (IDLE, BUS with immediate ready, DONE).
//     Each additional bus wait state adds 1 cycle.
//   Strobes, with o=addr[1:0]:
//     - B: 4'b0001<<o.
//     - H: 4'b0011<<o.
//     - W: 4'b1111.
//     - bus_wdata = core_wdata << (8*o).
//   Load formatting:
//     - Select the byte or halfword at offset o from bus_rdata.
//     - B/H sign-extend; BU/HU zero-extend; W passes through.
//   core_rdata is 0 outside DONE and on faults. Writes never modify core_rdata.
//   Non-memory instructions (core_req=0) pass with zero stall.
// TESTING
//   - LW addr 0x100, ready in 1st BUS cycle, rdata 0xDEADBEEF
//     -> bus_addr 0x100, wstrb 0000, stall 2 cycles, DONE core_rdata 0xDEADBEEF.
//   - SB addr 0x203, wdata 0x000000A5
//     -> bus_addr 0x200, wstrb 1000, bus_wdata 0xA5000000, bus_we=1.
//   - LB addr 0x2, rdata 0x0080_0000 -> core_rdata 0xFFFFFF80.
//     LBU same -> 0x00000080.
//     LHU addr 0x2, rdata 0x8001_0000 -> 0x00008001.
//   - LW addr 0x102 -> no bus_valid, DONE with core_fault=1, core_rdata 0.
//     SH addr 0x1 -> same.
//   - bus_ready held 0 with TIMEOUT_CYCLES=4 -> bus_valid for exactly 4 cycles,
//     then fault pulse.
//     bus_ready=1 with bus_err=1 -> fault pulse.
//   - rstn low in 2nd BUS cycle -> bus_valid/core_stall 0 immediately, state IDLE,
//     no fault or rdata after release.

Source files
------------

// File: rtl/dbus_bridge.sv
// dbus_bridge: turns one core load/store into one valid/ready bus transaction.
//
// Ports
//   clk, rstn      rising-edge clock, asynchronous active-low reset
//   core_req       load/store present this cycle
//   core_we        1=store, 0=load
//   core_func      funct3 (B/H/W/BU/HU)
//   core_addr      byte address
//   core_wdata     LSB-aligned store data
//   core_rdata     extended load data, non-zero only in DONE
//   core_stall     hold PC / suppress regfile write
//   core_fault     one-cycle fault pulse in DONE
//   bus_valid      request valid (BUS state)
//   bus_ready      target accepts/completes this cycle
//   bus_we         write enable
//   bus_addr       word-aligned address
//   bus_wstrb      byte strobes (0000 on reads)
//   bus_wdata      lane-shifted store data
//   bus_rdata      read data, sampled on handshake
//   bus_err        error response, qualified by bus_ready
//
// Flow: IDLE -> BUS (wait states) -> DONE (1 cycle) -> IDLE.
// Misaligned or illegal funct3 go IDLE -> DONE with fault and no bus cycle.
module dbus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [2:0]  core_func,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [3:0]      wstrb_q;
  logic [2:0]      func_q;
  logic [1:0]      off_q;
  logic            we_q, fault_q;

  logic [1:0]      off;
  logic            aligned;
  logic [3:0]      wstrb_c;
  logic [31:0]     rd_sh, rd_fmt;
  logic            timeout;

  assign off     = core_addr[1:0];
  assign timeout = (cnt == TO_LAST);

  // Illegal funct3 encodings fall into the default and fault like misalignment.
  always_comb begin
    aligned = 1'b0;
    case (core_func)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = ~off[0];
      3'b010:         aligned = (off == 2'b00);
      default:        aligned = 1'b0;
    endcase
  end

  always_comb begin
    wstrb_c = 4'b0000;
    if (core_we) begin
      case (core_func[1:0])
        2'b00:   wstrb_c = 4'b0001 << off;
        2'b01:   wstrb_c = 4'b0011 << off;
        default: wstrb_c = 4'b1111;
      endcase
    end
  end

  // Bring the addressed byte/halfword down to bit 0, then extend.
  assign rd_sh = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    rd_fmt = bus_rdata;
    case (func_q)
      3'b000:  rd_fmt = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  rd_fmt = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  rd_fmt = {24'h0, rd_sh[7:0]};
      3'b101:  rd_fmt = {16'h0, rd_sh[15:0]};
      default: rd_fmt = bus_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (core_req) state_nxt = aligned ? BUS : DONE;
      BUS:     if (bus_ready || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      func_q  <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (core_req) begin
            rdata_q <= '0;
            fault_q <= ~aligned;
            if (aligned) begin
              addr_q  <= {core_addr[31:2], 2'b00};
              off_q   <= off;
              we_q    <= core_we;
              func_q  <= core_func;
              wstrb_q <= wstrb_c;
              wdata_q <= core_wdata << {off, 3'b000};
            end
          end
        end
        BUS: begin
          if (bus_ready) begin
            // Errored reads and all writes report zero data.
            rdata_q <= (we_q || bus_err) ? 32'h0 : rd_fmt;
            fault_q <= bus_err;
          end else if (timeout) begin
            rdata_q <= '0;
            fault_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus_valid  = (state == BUS);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_wdata  = wdata_q;

  // rstn gates the IDLE pass-through so stall also drops the instant reset asserts.
  assign core_stall = rstn & ((state == BUS) | ((state == IDLE) & core_req));
  assign core_rdata = (state == DONE) ? rdata_q : 32'h0;
  assign core_fault = (state == DONE) & fault_q;

endmodule

// File: tb/tb_dbus_bridge.sv
module tb_dbus_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        core_req, core_we;
  logic [2:0]  core_func;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall, core_fault;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dbus_bridge #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .core_req(core_req), .core_we(core_we), .core_func(core_func),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .core_fault(core_fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  typedef struct {
    string       nm;
    logic        we;
    logic [2:0]  func;
    logic [31:0] addr, wdata, rdata;
    int          dly;       // wait states before bus_ready (>=4 -> timeout)
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_rdata;
    logic        e_fault;
    int          e_vcyc;    // bus_valid cycles expected
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int  vcnt = 0;
    int  scnt = 0;
    bit  done = 0;
    @(negedge clk);
    core_req = 1'b1; core_we = v.we; core_func = v.func;
    core_addr = v.addr; core_wdata = v.wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus_valid) begin
        if (vcnt == 0) begin
          chk({v.nm, " bus_addr"}, bus_addr, v.e_addr);
          chk({v.nm, " bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, v.e_strb});
          chk({v.nm, " bus_we"}, {31'h0, bus_we}, {31'h0, v.we});
          if (v.we) chk({v.nm, " bus_wdata"}, bus_wdata, v.e_wdata);
        end
        bus_ready = (vcnt == v.dly);
        bus_rdata = v.rdata;
        bus_err   = v.err;
        vcnt++;
      end else begin
        bus_ready = 1'b0;
        bus_err   = 1'b0;
      end
      if (core_stall) scnt++;
      else begin
        done = 1;
        chk({v.nm, " core_rdata"}, core_rdata, v.e_rdata);
        chk({v.nm, " core_fault"}, {31'h0, core_fault}, {31'h0, v.e_fault});
        chk({v.nm, " valid_cycles"}, vcnt, v.e_vcyc);
        chk({v.nm, " stall_cycles"}, scnt, v.e_vcyc + 1);
      end
      @(negedge clk);
    end
    if (!done) chk({v.nm, " completion_bound"}, 32'd0, 32'd1);
    core_req = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
    #1;
    chk({v.nm, " idle_rdata"}, core_rdata, 32'h0);
    chk({v.nm, " idle_fault"}, {31'h0, core_fault}, 32'h0);
  endtask

  initial begin
    rstn = 1'b0; core_req = 1'b0; core_we = 1'b0; core_func = 3'b0;
    core_addr = '0; core_wdata = '0; bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;

    //          nm        we  func   addr          wdata         rdata         dly err e_addr        e_strb   e_wdata       e_rdata       flt vcyc
    vecs[0]  = '{"LW",    0, 3'd2, 32'h100,     32'h0,        32'hDEADBEEF, 0, 0, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 1};
    vecs[1]  = '{"SB",    1, 3'd0, 32'h203,     32'h000000A5, 32'h0,        0, 0, 32'h200, 4'b1000, 32'hA5000000, 32'h0,        0, 1};
    vecs[2]  = '{"LB",    0, 3'd0, 32'h2,       32'h0,        32'h00800000, 0, 0, 32'h0,   4'b0000, 32'h0,        32'hFFFFFF80, 0, 1};
    vecs[3]  = '{"LBU",   0, 3'd4, 32'h2,       32'h0,        32'h00800000, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h00000080, 0, 1};
    vecs[4]  = '{"LHU",   0, 3'd5, 32'h2,       32'h0,        32'h80010000, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h00008001, 0, 1};
    vecs[5]  = '{"LH",    0, 3'd1, 32'h2,       32'h0,        32'h80010000, 0, 0, 32'h0,   4'b0000, 32'h0,        32'hFFFF8001, 0, 1};
    vecs[6]  = '{"LWmis", 0, 3'd2, 32'h102,     32'h0,        32'h12345678, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 0};
    vecs[7]  = '{"SHmis", 1, 3'd1, 32'h1,       32'h1234,     32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 0};
    vecs[8]  = '{"SHw2",  1, 3'd1, 32'h12,      32'h1234ABCD, 32'h0,        2, 0, 32'h10,  4'b1100, 32'hABCD0000, 32'h0,        0, 3};
    vecs[9]  = '{"SW",    1, 3'd2, 32'h44,      32'hCAFEF00D, 32'hFFFFFFFF, 0, 0, 32'h44,  4'b1111, 32'hCAFEF00D, 32'h0,        0, 1};
    vecs[10] = '{"LBw1",  0, 3'd0, 32'h1,       32'h0,        32'h00007F00, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0000007F, 0, 2};
    vecs[11] = '{"LWto",  0, 3'd2, 32'h8,       32'h0,        32'h55555555, 99, 0, 32'h8,  4'b0000, 32'h0,        32'h0,        1, 4};
    vecs[12] = '{"LWerr", 0, 3'd2, 32'h8,       32'h0,        32'h00001111, 0, 1, 32'h8,   4'b0000, 32'h0,        32'h0,        1, 1};
    vecs[13] = '{"ILL",   0, 3'd3, 32'h0,       32'h0,        32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 0};
    vecs[14] = '{"SWerr", 1, 3'd2, 32'hF0,      32'h01020304, 32'h0,        0, 1, 32'hF0,  4'b1111, 32'h01020304, 32'h0,        1, 1};
    vecs[15] = '{"LH0",   0, 3'd1, 32'hABC0,    32'h0,        32'h12348765, 0, 0, 32'hABC0,4'b0000, 32'h0,        32'hFFFF8765, 0, 1};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst core_stall", {31'h0, core_stall}, 32'h0);
    chk("rst core_fault", {31'h0, core_fault}, 32'h0);
    chk("rst core_rdata", core_rdata, 32'h0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
    rstn = 1'b1;

    // Zero-stall pass-through for non-memory instructions.
    @(negedge clk); #1;
    chk("nomem stall", {31'h0, core_stall}, 32'h0);

    for (int i = 0; i < 16; i++) run(vecs[i]);

    // Reset asserted in the 2nd BUS cycle of a load that never gets ready.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_func = 3'd2; core_addr = 32'h100;
    @(negedge clk); #1;
    chk("mid first bus_valid", {31'h0, bus_valid}, 32'h1);
    @(negedge clk); #1;
    chk("mid second bus_valid", {31'h0, bus_valid}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("mid rst bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("mid rst core_stall", {31'h0, core_stall}, 32'h0);
    core_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("post rst bus_valid", {31'h0, bus_valid}, 32'h0);
      chk("post rst core_fault", {31'h0, core_fault}, 32'h0);
      chk("post rst core_rdata", core_rdata, 32'h0);
    end
    bus_ready = 1'b0;

    // Bridge still works after the abort.
    run(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
